mvm_stream_engine: RTL and testbench

//  Responder end of the matrix-vector stream protocol: accepts a K*K matrix W, then a K-vector x,
//  as 14-bit signed words on a valid/ready input, and returns y = W*x as K 28-bit signed words.

---
 rtl/mvm_pkg.sv | 20 ++
 rtl/mvm_mac_lane.sv | 64 ++++++
 rtl/mvm_stream_engine.sv | 139 +++++++++++++
 tb/tb_mvm_stream_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and sizing for the matrix-vector stream engine.
// MVM_SAT_EN selects a widened, saturating accumulator in mvm_mac_lane.
package mvm_pkg;
   localparam int K     = 3;
   localparam int IN_W  = 14;
   localparam int OUT_W = 28;
   localparam int AW    = $clog2(K*K);
   localparam int RW    = $clog2(K);
   localparam int CW    = $clog2(K+2);

   typedef logic signed [IN_W-1:0]  mvm_in_t;
   typedef logic signed [OUT_W-1:0] mvm_out_t;

   typedef enum logic [1:0] {
      LOAD_W,
      LOAD_X,
      COMPUTE,
      OUT
   } mvm_state_t;
endpackage

// File: rtl/mvm_mac_lane.sv
// Registered multiply followed by accumulate; clr_i zeroes both stages.
// MVM_SAT_EN: accumulator grows by $clog2(K) bits and res_o is clamped.
module mvm_mac_lane
   import mvm_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     clr_i,
   input  logic     issue_i,
   input  logic     acc_en_i,
   input  mvm_in_t  a_i,
   input  mvm_in_t  b_i,
   output mvm_out_t res_o
);
`ifdef MVM_SAT_EN
   localparam int ACC_W = OUT_W + $clog2(K);
`else
   localparam int ACC_W = OUT_W;
`endif

   mvm_out_t                prod_q, prod_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;

   always_comb begin
      prod_d = prod_q;
      acc_d  = acc_q;
      if (clr_i) begin
         prod_d = '0;
         acc_d  = '0;
      end else begin
         if (issue_i)
            prod_d = mvm_out_t'(a_i) * mvm_out_t'(b_i);
         if (acc_en_i)
            acc_d = acc_q + ACC_W'(prod_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

`ifdef MVM_SAT_EN
   logic fits;
   // In range when all bits above the output sign bit agree with it
   always_comb begin
      fits = (acc_q[ACC_W-1:OUT_W-1] == '0) ||
             (acc_q[ACC_W-1:OUT_W-1] == '1);
      if (fits)
         res_o = acc_q[OUT_W-1:0];
      else if (acc_q[ACC_W-1])
         res_o = {1'b1, {(OUT_W-1){1'b0}}};
      else
         res_o = {1'b0, {(OUT_W-1){1'b1}}};
   end
`else
   assign res_o = acc_q;
`endif
endmodule

// File: rtl/mvm_stream_engine.sv
// Streams in W (row-major) then x, returns y = W*x one row at a time.
// Build with MVM_SAT_EN for saturating rather than wrapping accumulation.
module mvm_stream_engine
   import mvm_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             input_valid,
   output logic             input_ready,
   input  logic [IN_W-1:0]  input_data,
   output logic             output_valid,
   input  logic             output_ready,
   output logic [OUT_W-1:0] output_data
);
   localparam logic [AW-1:0] W_LAST  = AW'(K*K-1);
   localparam logic [AW-1:0] X_LAST  = AW'(K-1);
   localparam logic [RW-1:0] R_LAST  = RW'(K-1);
   localparam logic [CW-1:0] C_ISSUE = CW'(K);
   localparam logic [CW-1:0] C_LAST  = CW'(K+1);

   mvm_state_t      state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   mvm_out_t        out_q, out_d;

   mvm_in_t         w_q [K*K];
   mvm_in_t         x_q [K];

   logic            w_we, x_we;
   logic            clr, issue, acc_en;
   logic            in_fire, out_fire;
   logic [AW-1:0]   widx;
   logic [RW-1:0]   xidx;
   mvm_out_t        lane_res;

   assign input_ready  = !reset &&
                         (state_q == LOAD_W || state_q == LOAD_X);
   assign output_valid = (state_q == OUT);
   assign output_data  = out_q;
   assign in_fire      = input_valid && input_ready;
   assign out_fire     = output_valid && output_ready;

   assign widx = AW'(row_q) * AW'(K) + AW'(cnt_q);
   assign xidx = RW'(cnt_q);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      w_we    = 1'b0;
      x_we    = 1'b0;
      clr     = 1'b0;
      issue   = 1'b0;
      acc_en  = 1'b0;
      unique case (state_q)
         LOAD_W: if (in_fire) begin
            w_we = 1'b1;
            if (addr_q == W_LAST) begin
               state_d = LOAD_X;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         LOAD_X: if (in_fire) begin
            x_we = 1'b1;
            if (addr_q == X_LAST) begin
               state_d = COMPUTE;
               addr_d  = '0;
               row_d   = '0;
               cnt_d   = '0;
               clr     = 1'b1;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         // K issue cycles, accumulate trails by one, then capture
         COMPUTE: begin
            issue  = (cnt_q < C_ISSUE);
            acc_en = (cnt_q != '0) && (cnt_q <= C_ISSUE);
            if (cnt_q == C_LAST) begin
               out_d   = lane_res;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: if (out_fire) begin
            if (row_q == R_LAST) begin
               state_d = LOAD_W;
               addr_d  = '0;
            end else begin
               row_d   = row_q + 1'b1;
               cnt_d   = '0;
               clr     = 1'b1;
               state_d = COMPUTE;
            end
         end
         default: state_d = LOAD_W;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_W;
         addr_q  <= '0;
         row_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we)
         w_q[addr_q] <= input_data;
      if (x_we)
         x_q[RW'(addr_q)] <= input_data;
   end

   mvm_mac_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (clr),
      .issue_i  (issue),
      .acc_en_i (acc_en),
      .a_i      (w_q[widx]),
      .b_i      (x_q[xidx]),
      .res_o    (lane_res)
   );
endmodule

// File: tb/tb_mvm_stream_engine.sv
// Self-checking bench for mvm_stream_engine with a randomized handshake
// driver and an arithmetic reference model (honours MVM_SAT_EN).
module tb_mvm_stream_engine;
   localparam int KK = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        input_valid;
   logic        input_ready;
   logic [13:0] input_data;
   logic        output_valid;
   logic        output_ready;
   logic [27:0] output_data;

   int checks = 0;
   int errors = 0;
   int tw [KK*KK];
   int tx [KK];

   always #5 clk = ~clk;

   mvm_stream_engine dut (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_data  (output_data)
   );

   function automatic int golden(input int r);
      longint      s;
      logic [27:0] t;
      s = 0;
      for (int j = 0; j < KK; j++)
         s += longint'(tw[r*KK+j]) * longint'(tx[j]);
`ifdef MVM_SAT_EN
      if (s > 134217727)  s = 134217727;
      if (s < -134217728) s = -134217728;
      return int'(s);
`else
      t = s[27:0];
      return int'(signed'(t));
`endif
   endfunction

   function automatic int rnd_word();
      return int'($urandom_range(16383)) - 8192;
   endfunction

   task automatic run_problem(input int vp, input int rp,
                              input int stall, input bit chk_lat);
      int          expv [KK];
      int          nin, nout, cyc, ecount, refe, stall_left, lat;
      bit          wait_lat, in_f, out_f;
      logic [27:0] held, od;
      for (int r = 0; r < KK; r++) expv[r] = golden(r);
      nin = 0; nout = 0; cyc = 0; ecount = 0; refe = 0;
      stall_left = stall; wait_lat = 0; held = '0;
      while (nout < KK && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         input_valid = (nin < KK*KK+KK) && ($urandom_range(99) < vp);
         if (nin < KK*KK)         input_data = 14'(tw[nin]);
         else if (nin < KK*KK+KK) input_data = 14'(tx[nin-KK*KK]);
         else                     input_data = 14'($urandom);
         output_ready = ($urandom_range(99) < rp);
         if (output_valid && stall_left > 0) output_ready = 1'b0;
         #1;
         if (output_valid && stall_left > 0) begin
            if (stall_left == stall) begin
               held = output_data;
            end else begin
               checks++;
               if (output_data !== held || input_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_hold: data=%0h rdy=%b want data=%0h rdy=0",
                           output_data, input_ready, held);
               end
            end
            stall_left--;
         end
         if (chk_lat && wait_lat && output_valid) begin
            lat = ecount - refe;
            checks++;
            if (lat != KK+2) begin
               errors++;
               $display("FAIL latency: got %0d edges want %0d", lat, KK+2);
            end
            wait_lat = 0;
         end
         in_f  = input_valid && input_ready;
         out_f = output_valid && output_ready;
         od    = output_data;
         @(posedge clk);
         ecount++;
         if (in_f) begin
            nin++;
            if (nin == KK*KK+KK) begin refe = ecount; wait_lat = 1; end
         end
         if (out_f) begin
            checks++;
            if (nin != KK*KK+KK || od !== 28'(expv[nout])) begin
               errors++;
               $display("FAIL y%0d: got %0d want %0d (inputs taken %0d)",
                        nout, $signed(od), expv[nout], nin);
            end
            nout++;
            if (nout < KK) begin refe = ecount; wait_lat = 1; end
         end
      end
      checks++;
      if (nout != KK) begin
         errors++;
         $display("FAIL timeout: got %0d outputs want %0d", nout, KK);
      end
      @(negedge clk);
      input_valid  = 1'b0;
      output_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; input_valid = 1'b0; output_ready = 1'b0;
      input_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks += 3;
      if (input_ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready: got %b want 0", input_ready);
      end
      if (output_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid: got %b want 0", output_valid);
      end
      if (output_data !== 28'd0) begin
         errors++; $display("FAIL rst_out_data: got %0h want 0", output_data);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (input_ready !== 1'b1) begin
         errors++; $display("FAIL post_rst_ready: got %b want 1", input_ready);
      end
   endtask

   task automatic test_identity();
      for (int i = 0; i < KK*KK; i++) tw[i] = (i % (KK+1) == 0) ? 1 : 0;
      tx[0] = 5; tx[1] = -7; tx[2] = 100;
      run_problem(100, 100, 0, 1'b1);
   endtask

   task automatic test_extremes();
      for (int i = 0; i < KK*KK; i++) tw[i] = 8191;
      for (int i = 0; i < KK; i++)    tx[i] = -8192;
      run_problem(100, 100, 0, 1'b0);
      for (int i = 0; i < KK*KK; i++) tw[i] = -8192;
      run_problem(70, 70, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < KK*KK; i++) tw[i] = rnd_word();
      for (int i = 0; i < KK; i++)    tx[i] = rnd_word();
      run_problem(100, 100, 50, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         input_valid = 1'b1;
         input_data  = 14'($urandom);
      end
      @(negedge clk);
      input_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      output_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (output_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_no_out: valid=%b want 0", output_valid);
         end
      end
      output_ready = 1'b0;
      for (int i = 0; i < KK*KK; i++) tw[i] = rnd_word();
      for (int i = 0; i < KK; i++)    tx[i] = rnd_word();
      run_problem(100, 100, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int p = 0; p < 200; p++) begin
         for (int i = 0; i < KK*KK; i++) tw[i] = rnd_word();
         for (int i = 0; i < KK; i++)    tx[i] = rnd_word();
         run_problem(int'($urandom_range(100, 20)),
                     int'($urandom_range(100, 20)), 0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_extremes();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
